// File: rtl/game_ctrl.sv
// Game-state controller: per-frame collision detection from pixel hit flags,
// IDLE/RUN/HIT/OVER sequencing and a saturating 4-digit BCD score with high score.
module game_ctrl #(
  parameter int MIN_OVERLAP = 4,
  parameter int SCORE_DIV   = 6,
  parameter int HIT_FRAMES  = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_animate,
  input  logic        i_active,
  input  logic        i_px_dino,
  input  logic        i_px_obst,
  input  logic        i_start,
  output logic        o_run,
  output logic        o_hit,
  output logic        o_game_over,
  output logic [15:0] o_score,
  output logic [15:0] o_hi_score
);

  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int TMR_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;

  state_t           state_q, state_d;
  logic             start_sync_p0, start_sync_p1, start_prev_p2;
  logic             start_evt;
  logic [7:0]       ov_cnt;
  logic             ov_px, frame_hit;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [15:0]      score_q, score_d, hi_q, hi_d;

  // BCD ripple increment; 9999 holds rather than wrapping.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_evt = start_sync_p1 & ~start_prev_p2;
  assign ov_px     = i_pix_stb & i_active & i_px_dino & i_px_obst;
  assign frame_hit = (ov_cnt >= 8'(MIN_OVERLAP));

  // Start synchronizer / edge detect and per-frame overlap counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_sync_p0 <= 1'b0;
      start_sync_p1 <= 1'b0;
      start_prev_p2 <= 1'b0;
      ov_cnt        <= 8'd0;
    end else begin
      start_sync_p0 <= i_start;
      start_sync_p1 <= start_sync_p0;
      start_prev_p2 <= start_sync_p1;
      if (i_animate)
        ov_cnt <= 8'd0;
      else if (ov_px && ov_cnt != 8'hFF)
        ov_cnt <= ov_cnt + 8'd1;
    end
  end

  // Game state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      tmr_q   <= '0;
      score_q <= 16'h0000;
      hi_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      score_q <= score_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tmr_d   = tmr_q;
    score_d = score_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_evt) begin
          state_d = RUN;
          score_d = 16'h0000;
          div_d   = '0;
        end
      end
      RUN: begin
        if (i_animate) begin
          if (frame_hit) begin
            state_d = HIT;
            tmr_d   = TMR_W'(HIT_FRAMES - 1);
          end else if (div_q == DIV_W'(SCORE_DIV - 1)) begin
            div_d   = '0;
            score_d = bcd_inc_sat(score_q);
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      HIT: begin
        if (i_animate) begin
          if (tmr_q == '0) begin
            state_d = OVER;
            if (score_q > hi_q) hi_d = score_q;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_run       = (state_q == RUN);
  assign o_hit       = (state_q == HIT);
  assign o_game_over = (state_q == OVER);
  assign o_score     = score_q;
  assign o_hi_score  = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start latency, scoring, overlap threshold,
// hit/over sequencing, high score and asynchronous reset.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_stb, animate, active, px_dino, px_obst, start;
  logic        run, hit, game_over;
  logic [15:0] score, hi_score;

  logic        f_animate, f_start;
  logic        f_run, f_hit, f_game_over;
  logic [15:0] f_score, f_hi_score;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_animate(animate),
    .i_active(active), .i_px_dino(px_dino), .i_px_obst(px_obst), .i_start(start),
    .o_run(run), .o_hit(hit), .o_game_over(game_over),
    .o_score(score), .o_hi_score(hi_score)
  );

  // Second instance with a divider of 1 so the BCD carry and saturation
  // corners are reachable in a short run.
  game_ctrl #(.MIN_OVERLAP(4), .SCORE_DIV(1), .HIT_FRAMES(2)) dut_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(1'b0), .i_animate(f_animate),
    .i_active(1'b0), .i_px_dino(1'b0), .i_px_obst(1'b0), .i_start(f_start),
    .o_run(f_run), .o_hit(f_hit), .o_game_over(f_game_over),
    .o_score(f_score), .o_hi_score(f_hi_score)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    animate = 1'b1;
    step(1);
    animate = 1'b0;
    step(1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic ffames(input int n);
    for (int i = 0; i < n; i++) begin
      f_animate = 1'b1;
      step(1);
      f_animate = 1'b0;
      step(1);
    end
  endtask

  task automatic pix(input logic stb, input logic act, input logic dn, input logic ob, input int n);
    for (int i = 0; i < n; i++) begin
      pix_stb = stb; active = act; px_dino = dn; px_obst = ob;
      step(1);
      pix_stb = 1'b0; active = 1'b0; px_dino = 1'b0; px_obst = 1'b0;
      step(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pix_stb = 0; animate = 0; active = 0; px_dino = 0; px_obst = 0; start = 0;
    f_animate = 0; f_start = 0;
    step(2);
    chk("rst_run", run, 0);
    chk("rst_hit", hit, 0);
    chk("rst_over", game_over, 0);
    chk("rst_score", score, 16'h0000);
    chk("rst_hi", hi_score, 16'h0000);
    rst_n = 1'b1;
    step(1);

    // Start latency: visible two edges after the sampling edge
    start = 1'b1;
    step(2);
    chk("start_lat_n1", run, 0);
    step(1);
    chk("start_lat_n2", run, 1);
    step(7);
    start = 1'b0;
    chk("start_score", score, 16'h0000);
    chk("start_hit", hit, 0);
    chk("start_over", game_over, 0);

    // BCD carry/saturation on the fast instance
    f_start = 1'b1;
    step(1);
    f_start = 1'b0;
    step(3);
    chk("fast_run", f_run, 1);
    ffames(999);
    chk("fast_0999", f_score, 16'h0999);
    ffames(1);
    chk("fast_1000", f_score, 16'h1000);
    ffames(8999);
    chk("fast_9999", f_score, 16'h9999);
    ffames(6);
    chk("fast_sat", f_score, 16'h9999);

    // Scoring: one increment per SCORE_DIV frames
    frames(5);
    chk("score_5fr", score, 16'h0000);
    frames(1);
    chk("score_6fr", score, 16'h0001);
    frames(54);
    chk("score_60fr", score, 16'h0010);
    frames(192);
    chk("score_0042", score, 16'h0042);

    // Below threshold plus pixels that must not count
    pix(1, 1, 1, 1, 3);
    pix(0, 1, 1, 1, 5);
    pix(1, 0, 1, 1, 5);
    pix(1, 1, 1, 0, 5);
    pix(1, 1, 0, 1, 5);
    frame();
    chk("ovl3_run", run, 1);
    chk("ovl3_hit", hit, 0);

    // Overlap pixel on the animate cycle is dropped
    pix(1, 1, 1, 1, 3);
    pix_stb = 1; active = 1; px_dino = 1; px_obst = 1; animate = 1;
    step(1);
    pix_stb = 0; active = 0; px_dino = 0; px_obst = 0; animate = 0;
    step(1);
    chk("ovl_coinc_run", run, 1);
    chk("ovl_coinc_score", score, 16'h0042);

    pulse_start();
    chk("start_in_run", run, 1);
    chk("start_in_run_score", score, 16'h0042);

    // Four pixels: freeze on this frame's animate edge
    pix(1, 1, 1, 1, 4);
    animate = 1'b1;
    step(1);
    chk("hit_edge_run", run, 0);
    chk("hit_edge_hit", hit, 1);
    animate = 1'b0;
    step(1);

    pulse_start();
    chk("start_in_hit", hit, 1);

    frames(29);
    chk("hit29_hit", hit, 1);
    chk("hit29_over", game_over, 0);
    chk("hit29_hi", hi_score, 16'h0000);
    frames(1);
    chk("hit30_over", game_over, 1);
    chk("hit30_hit", hit, 0);
    chk("hi_0042", hi_score, 16'h0042);
    chk("over_score", score, 16'h0042);

    // Restart from OVER with start_evt landing on an animate cycle
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    animate = 1'b1;
    step(1);
    animate = 1'b0;
    chk("restart_run", run, 1);
    chk("restart_score", score, 16'h0000);
    chk("restart_hi", hi_score, 16'h0042);
    step(1);
    frames(180);
    chk("replay_0030", score, 16'h0030);
    pix(1, 1, 1, 1, 4);
    frame();
    chk("replay_hit", hit, 1);
    frames(30);
    chk("replay_over", game_over, 1);
    chk("replay_hi_kept", hi_score, 16'h0042);

    // Reset mid-run
    pulse_start();
    chk("run3", run, 1);
    frames(738);
    chk("score_0123", score, 16'h0123);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_run", run, 0);
    chk("arst_hit", hit, 0);
    chk("arst_over", game_over, 0);
    chk("arst_score", score, 16'h0000);
    chk("arst_hi", hi_score, 16'h0000);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_run", run, 0);
    chk("post_rst_over", game_over, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-state controller downstream of the VGA top-level pixel compositor. It consumes the per-pixel dino and obstacle hit flags during active video and turns them into a per-frame collision decision. A four-state FSM drives the run/freeze/game-over flags that gate sprite animation. It also keeps a 4-digit BCD score and a high score for the score overlay.

## Interface
Parameters:
- MIN_OVERLAP, 4: overlapping pixels in one frame required to declare a hit.
- SCORE_DIV, 6: RUN frames per score increment.
- HIT_FRAMES, 30: frames spent frozen in HIT before entering OVER.

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_pix_stb  in  1  pixel strobe. Pixel inputs are sampled only when high.
- i_animate  in  1  one-cycle end-of-frame pulse from the VGA timing block.
- i_active  in  1  current pixel is inside the 640x480 visible area.
- i_px_dino  in  1  current pixel is inside the dinosaur.
- i_px_obst  in  1  current pixel is inside any cactus or bird (OR-reduced upstream).
- i_start  in  1  raw start button, asynchronous, active-high.
- o_run  out  1  obstacles and dino may advance this frame.
- o_hit  out  1  high while in HIT (overlay flash).
- o_game_over  out  1  high while in OVER.
- o_score  out  16  current score, 4 BCD digits, [15:12] most significant.
- o_hi_score  out  16  best score since reset, BCD.

## Operation
- Start input: 2-flop synchronizer, then a previous-value flop. start_evt = sync2 & ~prev.
- Overlap counter:
  - 8-bit, saturating at 255.
  - Increments when i_pix_stb & i_active & i_px_dino & i_px_obst, and i_animate is low.
  - Cleared on every i_animate. A sample coinciding with i_animate is dropped.
- frame_hit = (overlap count >= MIN_OVERLAP), evaluated on the i_animate cycle using the pre-clear count.
- FSM states: IDLE, RUN, HIT, OVER.
  - IDLE: outputs low except the scores. start_evt -> RUN; o_score cleared, frame divider cleared.
  - RUN: o_run=1.
    - On i_animate: if frame_hit, go to HIT and load the hit timer with HIT_FRAMES-1.
    - Otherwise advance the frame divider (0..SCORE_DIV-1). On wrap, increment the score.
  - HIT: o_run=0, o_hit=1.
    - On each i_animate, decrement the hit timer. On i_animate with timer=0 -> OVER.
    - On that same transition, o_hi_score <= o_score if o_score > o_hi_score (BCD compare is equal to binary compare of the 16-bit word).
  - OVER: o_game_over=1. start_evt -> RUN with score and divider cleared; o_hi_score is kept.
- start_evt in RUN or HIT is ignored.
- Score increment: BCD ripple, each digit 9 -> 0 with carry into the next digit. 9999 saturates and does not wrap.
- Any start_evt arriving on an i_animate cycle in IDLE/OVER is still taken. The overlap counter is still cleared that cycle.
- Reset mid-game: everything returns to reset values immediately, including o_hi_score=0.

## Timing
- Reset values:
  - state=IDLE.
  - o_run=0, o_hit=0, o_game_over=0.
  - o_score=16'h0000, o_hi_score=16'h0000.
  - Counters 0; synchronizer flops 0.
- All outputs are registered and decoded from the state register, with no combinational path from inputs to outputs.
- Start latency: i_start sampled high at edge N, then sync1 at N, sync2 at N+1, and the state and o_run update at edge N+2. Visible 2 cycles after the sampling edge.
- Collision latency: the hit is decided at the i_animate edge ending the frame. o_run falls and o_hit rises on that same edge, so sprites freeze before the next frame starts.
- The score updates on the i_animate edge that wraps the divider. o_score changes at most once per frame.
- HIT lasts exactly HIT_FRAMES i_animate pulses. OVER is entered on the HIT_FRAMES-th pulse after the hit.
- i_animate is assumed to be a single cycle wide and to occur in blanking, with i_active low.

## Test plan
- Reset, then pulse i_start 10 cycles -> o_run=1 exactly 2 cycles after the sampling edge; o_score=0000. o_hit and o_game_over stay 0.
- RUN with no overlap for 60 frames (SCORE_DIV=6) -> o_score=0010. Preload the score to 0999 and run 6 frames -> 1000. Preload 9999 and run 6 frames -> stays 9999.
- Overlap thresholds across frames:
  - 3 overlapping strobed pixels -> no hit, o_run stays 1.
  - Next frame, 4 pixels -> on that frame's i_animate edge o_run=0 and o_hit=1.
  - Overlap pixels with i_pix_stb=0 or i_active=0 are not counted.
- Hit sequence with score 0042 and hi 0000 -> o_hit for exactly 30 i_animate pulses, then o_game_over=1 and o_hi_score=0042. Replay to score 0030 and die -> hi stays 0042.
- i_start pulses during RUN and HIT -> no state change. An overlap pixel coincident with i_animate -> not counted.
- Assert i_rst_n=0 asynchronously mid-RUN with score 0123 -> all outputs at reset values before the next clock edge. Release reset -> IDLE.
